// File: rtl/io_pkg.sv
// Shared io-block types and timing constants (LED stretcher, button debounce).
package io_pkg;

  typedef enum logic [1:0] {IDLE, ON, GAP} blink_state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 50000000;
  localparam int unsigned BLINK_10MS     = CLK_HZ_DEFAULT / 100;

endpackage

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle event strobes into distinct LED blinks with a
// guaranteed on-time and off-gap; events arriving mid-blink are queued.
module led_pulse_stretch
  import io_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned ON_CYCLES  = CLK_HZ / 100,
  parameter int unsigned OFF_CYCLES = CLK_HZ / 100,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_i,
  input  logic              clr_ovf_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] T_ON     = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] T_OFF    = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = {PEND_W{1'b1}};

  blink_state_t      state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;

  logic timer_done_c;
  logic enq_c;
  logic deq_c;
  logic drop_c;

  assign timer_done_c = (timer_q == '0);

  // Next-state: blink sequencing, pending queue and sticky overflow.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    enq_c   = 1'b0;
    deq_c   = 1'b0;
    drop_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (event_i) begin
          state_d = ON;
          timer_d = T_ON;
        end
      end
      ON: begin
        enq_c = event_i;
        if (timer_done_c) begin
          state_d = GAP;
          timer_d = T_OFF;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (timer_done_c) begin
          if (pend_q != '0) begin
            state_d = ON;
            timer_d = T_ON;
            deq_c   = 1'b1;
            enq_c   = event_i;
          end else if (event_i) begin
            // Empty queue: the coincident event is consumed directly.
            state_d = ON;
            timer_d = T_ON;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
          enq_c   = event_i;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (deq_c && !enq_c) begin
      pend_d = pend_q - PEND_W'(1);
    end else if (enq_c && !deq_c) begin
      if (pend_q == PEND_FULL) begin
        drop_c = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end

    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end

    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_o      = led_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Bench for led_pulse_stretch: schedule-based reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_led_pulse_stretch;

  localparam int unsigned ON_C   = 4;
  localparam int unsigned OFF_C  = 3;
  localparam int unsigned PW     = 2;
  localparam int          PMAX   = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          event_i;
  logic          clr_ovf_i;
  logic          led_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
  logic          overflow_o;

  int n_tests;
  int n_fail;
  int k;
  bit chk_en;

  led_pulse_stretch #(
    .CLK_HZ    (1000),
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .PEND_W    (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .event_i   (event_i),
    .clr_ovf_i (clr_ovf_i),
    .led_o     (led_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  // Reference: each blink is identified by the cycle s in which its event was
  // taken; LED high in cycles s+1..s+ON, busy through s+ON+OFF, and the next
  // blink can only be taken in cycle s+ON+OFF.
  int m_cyc;
  int m_s;
  int m_pend;
  bit m_act;
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    int  s, p;
    bit  a, o, drop;
    if (!rst_n) begin
      m_cyc  <= 0;
      m_s    <= 0;
      m_pend <= 0;
      m_act  <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      s = m_s; p = m_pend; a = m_act; o = m_ovf; drop = 1'b0;
      if (a && m_cyc == s + ON_C + OFF_C) begin
        if (p > 0) begin
          s = m_cyc;
          p = p - 1 + (event_i ? 1 : 0);
        end else if (event_i) begin
          s = m_cyc;
        end else begin
          a = 1'b0;
        end
      end else if (!a) begin
        if (event_i) begin
          a = 1'b1;
          s = m_cyc;
        end
      end else if (event_i) begin
        if (p == PMAX) drop = 1'b1;
        else p = p + 1;
      end
      if (drop) o = 1'b1;
      else if (clr_ovf_i) o = 1'b0;
      m_s    <= s;
      m_pend <= p;
      m_act  <= a;
      m_ovf  <= o;
      m_cyc  <= m_cyc + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int d;
    bit e_led;
    if (chk_en) begin
      d     = m_cyc - m_s;
      e_led = m_act && (d >= 1) && (d <= int'(ON_C));
      check("model_led",      int'(led_o),      int'(e_led));
      check("model_busy",     int'(busy_o),     int'(m_act));
      check("model_pending",  int'(pending_o),  m_pend);
      check("model_overflow", int'(overflow_o), int'(m_ovf));
    end
  end

  // Present inputs for the current cycle, then advance to mid-next-cycle.
  task automatic cyc_in(input logic ev, input logic clr);
    event_i   = ev;
    clr_ovf_i = clr;
    @(negedge clk);
    k++;
  endtask

  initial begin
    int  blinks;
    bit  prev;
    n_tests = 0; n_fail = 0; k = 0; chk_en = 1'b0;
    event_i = 1'b0; clr_ovf_i = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led",      int'(led_o),      0);
    check("reset_busy",     int'(busy_o),     0);
    check("reset_pending",  int'(pending_o),  0);
    check("reset_overflow", int'(overflow_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Single strobe.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc_in(i == 0, 1'b0);
      if (k >= 1 && k <= 4) check("s1_led_on", int'(led_o), 1);
      if (k >= 5 && k <= 7) begin
        check("s1_gap_led", int'(led_o), 0);
        check("s1_gap_busy", int'(busy_o), 1);
      end
      if (k == 8) check("s1_idle_busy", int'(busy_o), 0);
      if (k == 3) check("s1_pending", int'(pending_o), 0);
    end

    // Three back-to-back strobes.
    k = 0;
    for (int i = 0; i < 25; i++) begin
      cyc_in(i < 3, 1'b0);
      if (k == 2) check("s2_pend1", int'(pending_o), 1);
      if (k == 3) check("s2_pend2", int'(pending_o), 2);
      if (k == 1 || k == 8 || k == 15) check("s2_blink_start", int'(led_o), 1);
      if (k == 7 || k == 14) check("s2_gap_before", int'(led_o), 0);
      if (k == 21) check("s2_busy_last", int'(busy_o), 1);
      if (k == 22) begin
        check("s2_busy_fall", int'(busy_o), 0);
        check("s2_no_ovf", int'(overflow_o), 0);
      end
    end

    // Five strobes into a depth-3 queue, then clear overflow.
    k = 0; blinks = 0; prev = 1'b0;
    for (int i = 0; i < 35; i++) begin
      cyc_in(i < 5, i == 30);
      if (led_o && !prev) blinks++;
      prev = led_o;
      if (k == 4) begin
        check("s3_pend_sat", int'(pending_o), 3);
        check("s3_ovf_pre", int'(overflow_o), 0);
      end
      if (k == 5)  check("s3_ovf_set", int'(overflow_o), 1);
      if (k == 30) check("s3_ovf_hold", int'(overflow_o), 1);
      if (k == 31) check("s3_ovf_clr", int'(overflow_o), 0);
    end
    check("s3_blink_count", blinks, 4);

    // Second strobe in the last gap cycle with an empty queue.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      cyc_in(i == 0 || i == 7, 1'b0);
      if (k == 7) check("s4_gap_led", int'(led_o), 0);
      if (k >= 8 && k <= 11) check("s4_led2", int'(led_o), 1);
      if (k >= 1 && k <= 14) check("s4_busy", int'(busy_o), 1);
      check("s4_pending", int'(pending_o), 0);
    end

    // Dense pattern: saturation, net-zero dequeue/enqueue, clear vs set.
    k = 0;
    for (int i = 0; i < 100; i++) begin
      cyc_in((i < 60) && (i % 3 != 2), (i % 17) == 9);
    end

    // Asynchronous reset mid-blink discards the blink and the queue.
    k = 0;
    cyc_in(1'b1, 1'b0);
    cyc_in(1'b1, 1'b0);
    event_i = 1'b0;
    check("s5_led_before", int'(led_o), 1);
    check("s5_pend_before", int'(pending_o), 1);
    rst_n = 1'b0;
    #1;
    check("s5_led_async", int'(led_o), 0);
    check("s5_pend_async", int'(pending_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc_in(1'b0, 1'b0);
      check("s5_led_after", int'(led_o), 0);
      check("s5_busy_after", int'(busy_o), 0);
      check("s5_pend_after", int'(pending_o), 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
